// File: rtl/traffic_pkg.sv
// Shared codes for the highway/farm-road traffic-light controller.
// Optional pedestrian-request feature is enabled by defining PED_REQ_EN.
package traffic_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10
    } lamp_t;

    typedef enum logic [1:0] {
        HG = 2'b00,   // highway green, farm red
        HY = 2'b01,   // highway yellow, farm red
        FG = 2'b10,   // highway red, farm green
        FY = 2'b11    // highway red, farm yellow
    } state_t;

    // Interval timer thresholds the controller is paired with.
    localparam int TL_CNT = 29;
    localparam int TS_CNT = 2;

    function automatic lamp_t highway_lamp(input state_t s);
        case (s)
            HG:      highway_lamp = GREEN;
            HY:      highway_lamp = YELLOW;
            default: highway_lamp = RED;
        endcase
    endfunction

    function automatic lamp_t farm_lamp(input state_t s);
        case (s)
            FG:      farm_lamp = GREEN;
            FY:      farm_lamp = YELLOW;
            default: farm_lamp = RED;
        endcase
    endfunction

endpackage

// File: rtl/traffic_sync.sv
// Multi-flop synchronizer for one asynchronous level input, cleared by reset.
module traffic_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the async level through STAGES flops; async active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/traffic_ctrl.sv
// Highway/farm-road traffic-light controller. Pulses sc to restart the
// interval timer on every state change and ignores tl/ts while sc is high,
// because the timer flags are stale during that cycle.
// Define PED_REQ_EN to add the ped_req input and walk output.
module traffic_ctrl
    import traffic_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       car,
    input  logic       tl,
    input  logic       ts,
    output logic       sc,
    output logic [1:0] hl,
    output logic [1:0] fl,
    output logic [1:0] state_o
`ifdef PED_REQ_EN
    ,
    input  logic       ped_req,
    output logic       walk
`endif
);

    state_t state;
    state_t state_nxt;
    logic   car_s;
    logic   ped_pend;
    logic   walk_q;

    traffic_sync #(.STAGES(SYNC_STAGES)) u_car_sync (
        .clk (clk),
        .rst (rst),
        .d   (car),
        .q   (car_s)
    );

`ifdef PED_REQ_EN
    logic ped_s;
    logic ped_prev;
    logic enter_fg;
    logic leave_fg;

    traffic_sync #(.STAGES(SYNC_STAGES)) u_ped_sync (
        .clk (clk),
        .rst (rst),
        .d   (ped_req),
        .q   (ped_s)
    );

    assign enter_fg = (state == HY) && (state_nxt == FG);
    assign leave_fg = (state == FG) && (state_nxt == FY);

    // Latch pedestrian requests until the farm green they are served by;
    // a request arriving on that very edge stays pending for the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ped_prev <= 1'b0;
            ped_pend <= 1'b0;
            walk_q   <= 1'b0;
        end else begin
            ped_prev <= ped_s;
            if (enter_fg) begin
                ped_pend <= 1'b0;
            end
            if (ped_s && !ped_prev) begin
                ped_pend <= 1'b1;
            end
            if (enter_fg) begin
                walk_q <= ped_pend;
            end else if (leave_fg) begin
                walk_q <= 1'b0;
            end
        end
    end

    assign walk = walk_q;
`else
    assign ped_pend = 1'b0;
    assign walk_q   = 1'b0;
`endif

    // Next-state decode; no transition is considered while sc is high.
    always_comb begin
        state_nxt = state;
        if (!sc) begin
            case (state)
                HG: if (tl && (car_s || ped_pend))  state_nxt = HY;
                HY: if (ts)                         state_nxt = FG;
                FG: if (tl || (!car_s && !walk_q))  state_nxt = FY;
                FY: if (ts)                         state_nxt = HG;
                default:                            state_nxt = HG;
            endcase
        end
    end

    // State, lamps and timer pulse all change together on a transition edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= HG;
            sc    <= 1'b0;
            hl    <= GREEN;
            fl    <= RED;
        end else begin
            state <= state_nxt;
            sc    <= (state_nxt != state);
            hl    <= highway_lamp(state_nxt);
            fl    <= farm_lamp(state_nxt);
        end
    end

    assign state_o = state;

endmodule
